// File: rtl/ram_port_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | ram_port_arbiter: two-port arbiter/sequencer for a 16x8 registered-read  |
// | RAM on a shared tri-state bus. Option macro: RAM_ARB_FIXED_PRIO_EN.      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module ram_port_arbiter #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_ack,
    output logic [DATA_W-1:0] a_rdata,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_ack,
    output logic [DATA_W-1:0] b_rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic              ram_re,
    inout  wire  [DATA_W-1:0] ram_data
);

    localparam logic [1:0] c_ST_IDLE    = 2'd0;
    localparam logic [1:0] c_ST_RD_ADDR = 2'd1;
    localparam logic [1:0] c_ST_RD_DATA = 2'd2;
    localparam logic [1:0] c_ST_WR      = 2'd3;

    localparam logic c_PORT_A = 1'b0;
    localparam logic c_PORT_B = 1'b1;

    logic [1:0]        r_state;
    logic              r_owner;
    logic [DATA_W-1:0] r_wdata;
`ifndef RAM_ARB_FIXED_PRIO_EN
    logic              r_last_grant;
`endif

    logic              w_a_elig;
    logic              w_b_elig;
    logic              w_any_elig;
    logic              w_grant_b;
    logic              w_sel_we;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [DATA_W-1:0] w_sel_wdata;

    // A request whose ack is high this cycle has just been served.
    assign w_a_elig   = a_req & ~a_ack;
    assign w_b_elig   = b_req & ~b_ack;
    assign w_any_elig = w_a_elig | w_b_elig;

    always_comb begin
        w_grant_b = 1'b0;
        if (w_a_elig && w_b_elig) begin
`ifdef RAM_ARB_FIXED_PRIO_EN
            w_grant_b = 1'b0;
`else
            w_grant_b = (r_last_grant == c_PORT_A);
`endif
        end else begin
            w_grant_b = w_b_elig;
        end
    end

    assign w_sel_we    = w_grant_b ? b_we    : a_we;
    assign w_sel_addr  = w_grant_b ? b_addr  : a_addr;
    assign w_sel_wdata = w_grant_b ? b_wdata : a_wdata;

    assign ram_data = (r_state == c_ST_WR) ? r_wdata : {DATA_W{1'bz}};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= c_ST_IDLE;
            r_owner      <= c_PORT_A;
            r_wdata      <= '0;
`ifndef RAM_ARB_FIXED_PRIO_EN
            r_last_grant <= c_PORT_B;
`endif
            ram_addr     <= '0;
            ram_we       <= 1'b0;
            ram_re       <= 1'b0;
            a_ack        <= 1'b0;
            b_ack        <= 1'b0;
            a_rdata      <= '0;
            b_rdata      <= '0;
        end else begin
            a_ack <= 1'b0;
            b_ack <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (w_any_elig) begin
                        r_owner  <= w_grant_b;
`ifndef RAM_ARB_FIXED_PRIO_EN
                        r_last_grant <= w_grant_b;
`endif
                        r_wdata  <= w_sel_wdata;
                        ram_addr <= w_sel_addr;
                        if (w_sel_we) begin
                            ram_we  <= 1'b1;
                            r_state <= c_ST_WR;
                        end else begin
                            ram_re  <= 1'b1;
                            r_state <= c_ST_RD_ADDR;
                        end
                    end
                end
                c_ST_RD_ADDR: begin
                    r_state <= c_ST_RD_DATA;
                end
                c_ST_RD_DATA: begin
                    if (r_owner == c_PORT_B) begin
                        b_rdata <= ram_data;
                        b_ack   <= 1'b1;
                    end else begin
                        a_rdata <= ram_data;
                        a_ack   <= 1'b1;
                    end
                    ram_re  <= 1'b0;
                    r_state <= c_ST_IDLE;
                end
                default: begin
                    ram_we <= 1'b0;
                    if (r_owner == c_PORT_B) begin
                        b_ack <= 1'b1;
                    end else begin
                        a_ack <= 1'b1;
                    end
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ram_port_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | tb_ram_port_arbiter: directed bench with a registered-read RAM model.    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_ram_port_arbiter;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 8;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              a_req = 1'b0, a_we = 1'b0;
    logic [ADDR_W-1:0] a_addr = '0;
    logic [DATA_W-1:0] a_wdata = '0;
    logic              a_ack;
    logic [DATA_W-1:0] a_rdata;
    logic              b_req = 1'b0, b_we = 1'b0;
    logic [ADDR_W-1:0] b_addr = '0;
    logic [DATA_W-1:0] b_wdata = '0;
    logic              b_ack;
    logic [DATA_W-1:0] b_rdata;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_we;
    logic              ram_re;
    wire  [DATA_W-1:0] ram_data;

    int n_checks = 0;
    int n_pass   = 0;
    logic mon_en = 1'b0;

    ram_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_ack(a_ack), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_ack(b_ack), .b_rdata(b_rdata),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_re(ram_re), .ram_data(ram_data)
    );

    always #5 clk = ~clk;

    // RAM model: address loaded on the first re edge, bus driven the cycle after.
    logic [DATA_W-1:0] mem [16];
    logic [DATA_W-1:0] r_buf = '0;
    logic              r_rd_valid = 1'b0;
    logic              w_ram_drv;
    assign w_ram_drv = ram_re & r_rd_valid;
    assign ram_data  = w_ram_drv ? r_buf : {DATA_W{1'bz}};

    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_data;
        if (ram_re) r_buf <= mem[ram_addr];
        r_rd_valid <= ram_re;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // A two-state simulator reads a released bus as zero.
    function automatic logic bus_released();
        logic [DATA_W-1:0] v;
        v = ram_data;
        return (v === {DATA_W{1'bz}}) || (v === '0);
    endfunction

    always @(negedge clk) begin
        if (rst_n && mon_en) begin
            check("we_re_exclusive", {31'd0, ram_we & ram_re}, 32'd0);
            check("single_ack", {31'd0, a_ack & b_ack}, 32'd0);
            if (!ram_we && !w_ram_drv) check("bus_idle_released", {31'd0, bus_released()}, 32'd1);
        end
    end

    typedef struct {
        logic              port_b;
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [DATA_W-1:0] exp_rdata;
    } vec_t;

    task automatic set_req(input logic port_b, input logic val, input logic we,
                           input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wdata);
        if (port_b) begin
            b_req = val; b_we = we; b_addr = addr; b_wdata = wdata;
        end else begin
            a_req = val; a_we = we; a_addr = addr; a_wdata = wdata;
        end
    endtask

    task automatic run_txn(input vec_t v);
        int   cyc = 0;
        int   re_cnt = 0;
        int   we_cnt = 0;
        logic got = 1'b0;
        logic other = 1'b0;
        @(negedge clk);
        set_req(v.port_b, 1'b1, v.we, v.addr, v.wdata);
        while (!got && cyc < 10) begin
            @(negedge clk);
            cyc++;
            if (ram_re) re_cnt++;
            if (ram_we) begin
                we_cnt++;
                check("wr_bus_data", {24'd0, ram_data}, {24'd0, v.wdata});
                check("wr_addr", {28'd0, ram_addr}, {28'd0, v.addr});
            end
            if (v.port_b ? a_ack : b_ack) other = 1'b1;
            got = v.port_b ? b_ack : a_ack;
        end
        set_req(v.port_b, 1'b0, 1'b0, '0, '0);
        check("ack_seen", {31'd0, got}, 32'd1);
        check("ack_latency", cyc, v.we ? 32'd2 : 32'd3);
        check("other_ack_quiet", {31'd0, other}, 32'd0);
        if (v.we) begin
            check("we_cycles", we_cnt, 32'd1);
            check("re_cycles_wr", re_cnt, 32'd0);
        end else begin
            check("re_cycles", re_cnt, 32'd2);
            check("rdata", {24'd0, v.port_b ? b_rdata : a_rdata}, {24'd0, v.exp_rdata});
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[9];
        vec_t v;
        logic [3:0] seq;
        int   n_ack;
        int   cyc;
        logic first_b;
        logic first_seen;
        logic a_done;
        logic b_done;

        for (int i = 0; i < 16; i++) mem[i] = '0;
        mem[0]  = 8'h1A;
        mem[1]  = 8'h2B;
        mem[5]  = 8'hE0;
        mem[10] = 8'h03;

        //           port_b we    addr   wdata  exp_rdata
        vecs[0] = '{1'b0, 1'b0, 4'hA, 8'h00, 8'h03};
        vecs[1] = '{1'b1, 1'b1, 4'hE, 8'h5A, 8'h00};
        vecs[2] = '{1'b1, 1'b0, 4'hE, 8'h00, 8'h5A};
        vecs[3] = '{1'b0, 1'b1, 4'h3, 8'h77, 8'h00};
        vecs[4] = '{1'b1, 1'b0, 4'h3, 8'h00, 8'h77};
        vecs[5] = '{1'b0, 1'b0, 4'hE, 8'h00, 8'h5A};
        vecs[6] = '{1'b1, 1'b1, 4'hF, 8'hFF, 8'h00};
        vecs[7] = '{1'b0, 1'b0, 4'hF, 8'h00, 8'hFF};
        vecs[8] = '{1'b1, 1'b0, 4'h0, 8'h00, 8'h1A};

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_ram_addr", {28'd0, ram_addr}, 32'd0);
        check("rst_ram_we", {31'd0, ram_we}, 32'd0);
        check("rst_ram_re", {31'd0, ram_re}, 32'd0);
        check("rst_acks", {30'd0, a_ack, b_ack}, 32'd0);
        check("rst_a_rdata", {24'd0, a_rdata}, 32'd0);
        check("rst_b_rdata", {24'd0, b_rdata}, 32'd0);
        check("rst_bus", {31'd0, bus_released()}, 32'd1);
        rst_n  = 1'b1;
        mon_en = 1'b1;

        for (int i = 0; i < 9; i++) run_txn(vecs[i]);
        @(negedge clk);
        check("a_rdata_held", {24'd0, a_rdata}, 32'h0000_00FF);
        check("b_rdata_held", {24'd0, b_rdata}, 32'h0000_001A);

        // Continuous contention: grants must alternate A,B,A,B.
        @(negedge clk);
        a_req = 1'b1; a_we = 1'b0; a_addr = 4'h0;
        b_req = 1'b1; b_we = 1'b0; b_addr = 4'h1;
        seq = '0; n_ack = 0; cyc = 0;
        while (n_ack < 4 && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (a_ack) begin
                seq[n_ack] = 1'b0; n_ack++;
                check("cont_a_rdata", {24'd0, a_rdata}, 32'h0000_001A);
            end
            if (b_ack) begin
                seq[n_ack] = 1'b1; n_ack++;
                check("cont_b_rdata", {24'd0, b_rdata}, 32'h0000_002B);
            end
        end
        a_req = 1'b0; b_req = 1'b0;
        check("cont_ack_count", n_ack, 32'd4);
        check("cont_grant_order", {28'd0, seq}, 32'b1010);

        // A served alone, then a tie: round-robin favours B, fixed priority A.
        v = '{1'b0, 1'b0, 4'hA, 8'h00, 8'h03};
        run_txn(v);
        @(negedge clk);
        a_req = 1'b1; a_we = 1'b0; a_addr = 4'h0;
        b_req = 1'b1; b_we = 1'b0; b_addr = 4'h1;
        first_seen = 1'b0; first_b = 1'b0; a_done = 1'b0; b_done = 1'b0; cyc = 0;
        while (!(a_done && b_done) && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (!first_seen && (a_ack || b_ack)) begin
                first_seen = 1'b1;
                first_b = b_ack;
            end
            if (a_ack) begin a_done = 1'b1; a_req = 1'b0; end
            if (b_ack) begin b_done = 1'b1; b_req = 1'b0; end
        end
        a_req = 1'b0; b_req = 1'b0;
        check("tie_both_served", {30'd0, a_done, b_done}, 32'b11);
`ifdef RAM_ARB_FIXED_PRIO_EN
        check("tie_first_grant", {31'd0, first_b}, 32'd0);
`else
        check("tie_first_grant", {31'd0, first_b}, 32'd1);
`endif

        // Reset during a write to 0x5 must drop it without touching memory.
        @(negedge clk);
        b_req = 1'b1; b_we = 1'b1; b_addr = 4'h5; b_wdata = 8'h99;
        @(negedge clk);
        check("abort_in_wr", {31'd0, ram_we}, 32'd1);
        #2;
        mon_en = 1'b0;
        rst_n  = 1'b0;
        #1;
        check("abort_we_async", {31'd0, ram_we}, 32'd0);
        check("abort_re_async", {31'd0, ram_re}, 32'd0);
        check("abort_addr_async", {28'd0, ram_addr}, 32'd0);
        check("abort_bus_async", {31'd0, bus_released()}, 32'd1);
        b_req = 1'b0; b_we = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check("abort_no_ack", {30'd0, a_ack, b_ack}, 32'd0);
        end
        rst_n  = 1'b1;
        mon_en = 1'b1;
        check("abort_mem_kept", {24'd0, mem[5]}, 32'h0000_00E0);
        v = '{1'b0, 1'b0, 4'h5, 8'h00, 8'hE0};
        run_txn(v);

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
